axil_reg_slave: RTL and testbench
=================================

AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter ID_VALUE, default 32'h5246_0001, constant returned by the ID register.
REQ-003 SHALL have port axi_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port axi_aresetn, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have ports awaddr/awprot/awvalid (in, ADDR_WIDTH/3/1) and awready (out, 1), the write-address channel.
REQ-006 SHALL have ports wdata/wstrb/wvalid (in, 32/4/1) and wready (out, 1), the write-data channel.
REQ-007 SHALL have ports bresp/bvalid (out, 2/1) and bready (in, 1), the write-response channel.
REQ-008 SHALL have ports araddr/arprot/arvalid (in, ADDR_WIDTH/3/1) and arready (out, 1), the read-address channel.
REQ-009 SHALL have ports rdata/rresp/rvalid (out, 32/2/1) and rready (in, 1), the read-data channel.
REQ-010 SHALL have port status_in, in, 32, live status sampled on read.
REQ-011 SHALL have port irq_in, in, 8, event pulses, one cycle per event.
REQ-012 SHALL have ports ctrl_out (out, 32), the CTRL register, and irq_out (out, 1), the interrupt request.

Function
REQ-013 Register map uses awaddr[4:2]/araddr[4:2]; any address with bits above bit 4 nonzero is out of range:
- 0x00 CTRL: RW.
- 0x04 SCRATCH: RW.
- 0x08 STATUS: RO, returns status_in.
- 0x0C IRQ_STAT: bits[7:0], write-1-to-clear.
- 0x10 ID: RO, returns ID_VALUE.
- 0x14/0x18/0x1C GP0-2: RW.
REQ-014 SHALL accept AW and W independently in any order or the same cycle; awready=1 iff no address held and bvalid=0; wready likewise for data.
REQ-015 AW handshake (awvalid&awready) SHALL latch awaddr; W handshake SHALL latch wdata/wstrb; each ready drops the next cycle.
REQ-016 Write FSM states: W_IDLE -> W_RESP when both address and data are held; the register update and bvalid=1 SHALL occur on that same edge (one cycle after the later handshake).
REQ-017 W_RESP SHALL hold bvalid/bresp stable until bready=1, then return to W_IDLE, clear the held flags, and re-assert awready/wready the next cycle.
REQ-018 RW writes SHALL honour wstrb per byte; wstrb=0 SHALL leave the register unchanged and still return OKAY.
REQ-019 Writes to STATUS or ID SHALL be ignored with bresp=OKAY; writes out of range SHALL be ignored with bresp=SLVERR (2'b10).
REQ-020 IRQ_STAT[i] SHALL set on irq_in[i]=1 and clear on a write with wdata[i]=1 (wstrb[0]=1); simultaneous set and clear SHALL leave the bit set.
REQ-021 irq_out SHALL be the registered |(IRQ_STAT & CTRL[7:0]), one cycle after the change.
REQ-022 Read FSM states: R_IDLE (arready=1) -> R_DATA on AR handshake, capturing data into rdata; rvalid=1 the next cycle; rdata/rresp SHALL be held until rready=1, then return to R_IDLE.
REQ-023 Out-of-range reads SHALL return rdata=32'hDEAD_BEEF with rresp=SLVERR; in-range reads SHALL return OKAY.
REQ-024 Read and write paths SHALL be fully independent; a read of a register written on the same edge returns the pre-write value.
REQ-025 awprot/arprot SHALL be ignored.

Reset
REQ-026 axi_aresetn=0 at a clock edge SHALL force:
- all registers, IRQ_STAT, ctrl_out and irq_out to 0;
- bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0;
- held flags cleared; both FSMs to IDLE;
- awready=wready=arready=0 while in reset, and 1 on the first edge after release.
REQ-027 Reset mid-transaction SHALL abort it; the interrupted write SHALL NOT update any register.

Verification
REQ-028 AW alone, then W 3 cycles later (0x04, 0x1234_5678) -> bvalid 1 cycle after the W handshake, OKAY; readback 0x1234_5678.
REQ-029 AW and W in the same cycle to 0x00, data 0xAABB_CCDD, wstrb=4'b0101 on prior 0 -> CTRL=0x00BB_00DD.
REQ-030 Read 0x10 -> rdata=ID_VALUE, OKAY; read 0x20 -> 0xDEAD_BEEF, SLVERR; write 0x20 -> SLVERR, no register changes.
REQ-031 irq_in[3] pulse with CTRL[3]=1 -> IRQ_STAT=0x08 and irq_out=1; write 0x08 to 0x0C together with a new irq_in[3] pulse -> bit stays set; clear alone -> irq_out=0.
REQ-032 bready and rready held low 5 cycles -> bvalid/rvalid, bresp and rdata held stable, no new AW/AR accepted; axi_aresetn pulse mid-W_RESP -> all outputs return to reset values.

Source files
------------

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: control/scratch/GP registers, live status, sticky IRQ
// status with write-1-to-clear, and independent read/write channel FSMs.
module axil_reg_slave #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h5246_0001
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [31:0]           status_in,
    input  logic [7:0]            irq_in,
    output logic [31:0]           ctrl_out,
    output logic                  irq_out
);

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic                  r_rdy_en;
    logic                  r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:2] r_aw_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [1:0]            r_bresp;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;

    logic [31:0]           r_ctrl, r_scratch;
    logic [2:0][31:0]      r_gp;
    logic [7:0]            r_irq_stat;
    logic                  r_irq;

    logic                  w_do_write, w_b_done;
    logic                  w_wr_oor, w_rd_oor;
    logic [2:0]            w_wr_idx, w_rd_idx;
    logic [7:0]            w_irq_clr;
    logic [31:0]           w_rd_data;
    logic [1:0]            w_rd_resp;
    logic                  w_unused;

    assign w_unused = &{1'b0, awprot, arprot, awaddr[1:0], araddr[1:0]};

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        f_merge = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) f_merge[8*i +: 8] = new_v[8*i +: 8];
    endfunction

    // Readies are gated by a flag that only rises on the first edge out of reset.
    assign awready  = r_rdy_en && !r_aw_held && (r_wstate == W_IDLE);
    assign wready   = r_rdy_en && !r_w_held  && (r_wstate == W_IDLE);
    assign arready  = r_rdy_en && (r_rstate == R_IDLE);
    assign bresp    = r_bresp;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;
    assign ctrl_out = r_ctrl;
    assign irq_out  = r_irq;

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_do_write   = 1'b0;
        w_b_done     = 1'b0;
        bvalid       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (r_aw_held && r_w_held) begin
                    w_do_write   = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_b_done     = 1'b1;
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        rvalid       = 1'b0;
        case (r_rstate)
            R_IDLE: if (arvalid && arready) w_rstate_nxt = R_DATA;
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_b_done) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= awaddr[ADDR_WIDTH-1:2];
            end
            if (wvalid && wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
        end
    end

    assign w_wr_idx  = r_aw_addr[4:2];
    assign w_wr_oor  = |r_aw_addr[ADDR_WIDTH-1:5];
    assign w_irq_clr = (w_do_write && !w_wr_oor && w_wr_idx == 3'd3 && r_wstrb[0])
                       ? r_wdata[7:0] : 8'h00;

    // A new event on the same edge as a clear wins, so no event is lost.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_ctrl     <= '0;
            r_scratch  <= '0;
            r_gp       <= '0;
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
            r_bresp    <= 2'b00;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_irq_clr) | irq_in;
            r_irq      <= |(r_irq_stat & r_ctrl[7:0]);
            if (w_do_write) begin
                r_bresp <= w_wr_oor ? 2'b10 : 2'b00;
                if (!w_wr_oor) begin
                    case (w_wr_idx)
                        3'd0:    r_ctrl    <= f_merge(r_ctrl,    r_wdata, r_wstrb);
                        3'd1:    r_scratch <= f_merge(r_scratch, r_wdata, r_wstrb);
                        3'd5:    r_gp[0]   <= f_merge(r_gp[0],   r_wdata, r_wstrb);
                        3'd6:    r_gp[1]   <= f_merge(r_gp[1],   r_wdata, r_wstrb);
                        3'd7:    r_gp[2]   <= f_merge(r_gp[2],   r_wdata, r_wstrb);
                        default: ;
                    endcase
                end
            end
        end
    end

    assign w_rd_idx = araddr[4:2];
    assign w_rd_oor = |araddr[ADDR_WIDTH-1:5];

    always_comb begin
        w_rd_data = 32'hDEAD_BEEF;
        w_rd_resp = 2'b10;
        if (!w_rd_oor) begin
            w_rd_resp = 2'b00;
            case (w_rd_idx)
                3'd0:    w_rd_data = r_ctrl;
                3'd1:    w_rd_data = r_scratch;
                3'd2:    w_rd_data = status_in;
                3'd3:    w_rd_data = {24'h0, r_irq_stat};
                3'd4:    w_rd_data = ID_VALUE;
                3'd5:    w_rd_data = r_gp[0];
                3'd6:    w_rd_data = r_gp[1];
                default: w_rd_data = r_gp[2];
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_rdata <= '0;
            r_rresp <= 2'b00;
        end else if (arvalid && arready) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Scoreboard bench for axil_reg_slave: expected read results are queued when a
// read is issued and popped when the response is collected.
module tb_axil_reg_slave;

    localparam logic [31:0] ID = 32'h5246_0001;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, status_in = 32'h0F0F_1234;
    logic [2:0]  awprot = 3'd0, arprot = 3'd0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [3:0]  wstrb = '0;
    logic [7:0]  irq_in = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq_out;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ctrl_out;

    int total = 0;
    int bad   = 0;

    typedef struct {logic [31:0] d; logic [1:0] r;} exp_t;
    exp_t sb[$];

    axil_reg_slave #(.ADDR_WIDTH(32), .ID_VALUE(ID)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .status_in(status_in), .irq_in(irq_in), .ctrl_out(ctrl_out), .irq_out(irq_out)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic timeout(input string what);
        total++;
        bad++;
        $display("FAIL timeout %s: got no handshake, required one within 20 cycles", what);
    endtask

    task automatic send_aw(input logic [31:0] a);
        awaddr = a; awvalid = 1;
        for (int n = 0; n < 20 && !awready; n++) tick();
        if (!awready) timeout("aw");
        tick();
        awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        wdata = d; wstrb = s; wvalid = 1;
        for (int n = 0; n < 20 && !wready; n++) tick();
        if (!wready) timeout("w");
        tick();
        wvalid = 0;
    endtask

    task automatic send_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int n = 0; n < 20 && !(awready && wready); n++) tick();
        if (!(awready && wready)) timeout("aw+w");
        tick();
        awvalid = 0; wvalid = 0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        for (int n = 0; n < 20 && !bvalid; n++) tick();
        if (!bvalid) timeout("b");
        resp = bresp;
        bready = 1;
        tick();
        bready = 0;
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        send_both(a, d, s);
        wait_b(resp);
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        araddr = a; arvalid = 1;
        for (int n = 0; n < 20 && !arready; n++) tick();
        if (!arready) timeout("ar");
        tick();
        arvalid = 0;
        for (int n = 0; n < 20 && !rvalid; n++) tick();
        if (!rvalid) timeout("r");
        d = rdata; r = rresp;
        rready = 1;
        tick();
        rready = 0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        e.d = d; e.r = r;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        axi_aresetn = 0;
        tick(); tick(); tick();
        total++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            bad++; $display("FAIL reset_hs got=%b exp=00000", {awready, wready, arready, bvalid, rvalid});
        end
        total++;
        if ({ctrl_out, rdata, bresp, rresp, irq_out} !== '0) begin
            bad++; $display("FAIL reset_out ctrl=%h rdata=%h bresp=%b rresp=%b irq=%b exp all zero",
                            ctrl_out, rdata, bresp, rresp, irq_out);
        end
        axi_aresetn = 1;
        tick();
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++; $display("FAIL reset_release_rdy got=%b exp=111", {awready, wready, arready});
        end
    endtask

    task automatic test_aw_then_w();
        logic [31:0] d; logic [1:0] r; exp_t e;
        send_aw(32'h04);
        total++;
        if ({awready, wready} !== 2'b01) begin
            bad++; $display("FAIL aw_held_rdy got=%b exp=01", {awready, wready});
        end
        tick(); tick(); tick();
        send_w(32'h1234_5678, 4'hF);
        total++;
        if (bvalid !== 1'b0) begin bad++; $display("FAIL b_early got=%b exp=0", bvalid); end
        tick();
        total++;
        if ({bvalid, bresp} !== 3'b100) begin
            bad++; $display("FAIL b_timing got=%b exp=100", {bvalid, bresp});
        end
        bready = 1; tick(); bready = 0;
        total++;
        if ({awready, wready, bvalid} !== 3'b110) begin
            bad++; $display("FAIL b_release got=%b exp=110", {awready, wready, bvalid});
        end
        push_exp(32'h1234_5678, 2'b00);
        read_reg(32'h04, d, r);
        e = sb.pop_front();
        total++;
        if (d !== e.d || r !== e.r) begin
            bad++; $display("FAIL scratch_rb got=%h/%b exp=%h/%b", d, r, e.d, e.r);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; exp_t e;
        logic [31:0] addrs[2] = '{32'h00, 32'h04};
        write_reg(32'h00, 32'hAABB_CCDD, 4'b0101, r);
        total++;
        if (r !== 2'b00 || ctrl_out !== 32'h00BB_00DD) begin
            bad++; $display("FAIL strb_ctrl got=%h/%b exp=00bb00dd/00", ctrl_out, r);
        end
        write_reg(32'h04, 32'hFFFF_FFFF, 4'b0000, r);
        total++;
        if (r !== 2'b00) begin bad++; $display("FAIL strb0_resp got=%b exp=00", r); end
        push_exp(32'h00BB_00DD, 2'b00);
        push_exp(32'h1234_5678, 2'b00);
        foreach (addrs[i]) begin
            read_reg(addrs[i], d, r);
            e = sb.pop_front();
            total++;
            if (d !== e.d || r !== e.r) begin
                bad++; $display("FAIL strb_rb[%0d] got=%h/%b exp=%h/%b", i, d, r, e.d, e.r);
            end
        end
    endtask

    task automatic test_id_oor();
        logic [31:0] d; logic [1:0] r; exp_t e;
        logic [31:0] wa[4]  = '{32'h08, 32'h10, 32'h20, 32'h24};
        logic [1:0]  wr[4]  = '{2'b00, 2'b00, 2'b10, 2'b10};
        logic [31:0] ra[6]  = '{32'h08, 32'h10, 32'h20, 32'h104, 32'h00, 32'h04};
        foreach (wa[i]) begin
            write_reg(wa[i], 32'h1111_1111, 4'hF, r);
            total++;
            if (r !== wr[i]) begin
                bad++; $display("FAIL wr_resp[%h] got=%b exp=%b", wa[i], r, wr[i]);
            end
        end
        push_exp(32'h0F0F_1234, 2'b00);
        push_exp(ID, 2'b00);
        push_exp(32'hDEAD_BEEF, 2'b10);
        push_exp(32'hDEAD_BEEF, 2'b10);
        push_exp(32'h00BB_00DD, 2'b00);
        push_exp(32'h1234_5678, 2'b00);
        foreach (ra[i]) begin
            read_reg(ra[i], d, r);
            e = sb.pop_front();
            total++;
            if (d !== e.d || r !== e.r) begin
                bad++; $display("FAIL rd[%h] got=%h/%b exp=%h/%b", ra[i], d, r, e.d, e.r);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r; exp_t e;
        logic [31:0] gpv[3] = '{32'hA0A0_0005, 32'hB1B1_0006, 32'hC2C2_0007};
        for (int i = 0; i < 3; i++) write_reg(32'h14 + 4*i, gpv[i], 4'hF, r);
        push_exp(32'h00BB_00DD, 2'b00);
        push_exp(32'h1234_5678, 2'b00);
        push_exp(32'h0F0F_1234, 2'b00);
        push_exp(32'h0, 2'b00);
        push_exp(ID, 2'b00);
        for (int i = 0; i < 3; i++) push_exp(gpv[i], 2'b00);
        for (int i = 0; i < 8; i++) begin
            read_reg(4*i, d, r);
            e = sb.pop_front();
            total++;
            if (d !== e.d || r !== e.r) begin
                bad++; $display("FAIL b2b_rd[%0d] got=%h/%b exp=%h/%b", i, d, r, e.d, e.r);
            end
        end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic [1:0] r; exp_t e;
        write_reg(32'h00, 32'h0000_0008, 4'hF, r);
        irq_in = 8'h02; tick(); irq_in = 8'h00; tick(); tick();
        total++;
        if (irq_out !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", irq_out); end
        write_reg(32'h0C, 32'h0000_0002, 4'h1, r);
        irq_in = 8'h08; tick(); irq_in = 8'h00;
        total++;
        if (irq_out !== 1'b0) begin bad++; $display("FAIL irq_lat got=%b exp=0", irq_out); end
        tick();
        total++;
        if (irq_out !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq_out); end
        push_exp(32'h08, 2'b00);
        read_reg(32'h0C, d, r);
        e = sb.pop_front();
        total++;
        if (d !== e.d || r !== e.r) begin
            bad++; $display("FAIL irq_stat got=%h/%b exp=%h/%b", d, r, e.d, e.r);
        end
        send_both(32'h0C, 32'h08, 4'h1);
        irq_in = 8'h08; tick(); irq_in = 8'h00;
        wait_b(r);
        push_exp(32'h08, 2'b00);
        read_reg(32'h0C, d, r);
        e = sb.pop_front();
        total++;
        if (d !== e.d || irq_out !== 1'b1) begin
            bad++; $display("FAIL irq_set_wins got=%h irq=%b exp=%h irq=1", d, irq_out, e.d);
        end
        write_reg(32'h0C, 32'h08, 4'h1, r);
        tick();
        push_exp(32'h00, 2'b00);
        read_reg(32'h0C, d, r);
        e = sb.pop_front();
        total++;
        if (d !== e.d || irq_out !== 1'b0) begin
            bad++; $display("FAIL irq_clear got=%h irq=%b exp=%h irq=0", d, irq_out, e.d);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [1:0] r;
        send_both(32'h14, 32'hA5A5_0001, 4'hF);
        for (int n = 0; n < 20 && !bvalid; n++) tick();
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
                bad++; $display("FAIL b_hold[%0d] got=%b exp=10000", c, {bvalid, bresp, awready, wready});
            end
            tick();
        end
        bready = 1; tick(); bready = 0;
        araddr = 32'h14; arvalid = 1; tick(); arvalid = 0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (rvalid !== 1'b1 || rdata !== 32'hA5A5_0001 || rresp !== 2'b00 || arready !== 1'b0) begin
                bad++; $display("FAIL r_hold[%0d] got=%b/%h/%b/%b exp=1/a5a50001/00/0",
                                c, rvalid, rdata, rresp, arready);
            end
            tick();
        end
        rready = 1; tick(); rready = 0;
        total++;
        if ({rvalid, arready} !== 2'b01) begin
            bad++; $display("FAIL r_release got=%b exp=01", {rvalid, arready});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; exp_t e;
        logic [31:0] ra[3] = '{32'h18, 32'h04, 32'h1C};
        write_reg(32'h04, 32'h55AA_55AA, 4'hF, r);
        irq_in = 8'h08; tick(); irq_in = 8'h00; tick(); tick();
        send_both(32'h18, 32'hCAFE_0000, 4'hF);
        tick();
        total++;
        if (bvalid !== 1'b1 || irq_out !== 1'b1) begin
            bad++; $display("FAIL pre_reset got=%b/%b exp=1/1", bvalid, irq_out);
        end
        axi_aresetn = 0; tick();
        total++;
        if ({awready, wready, arready, bvalid, rvalid, irq_out} !== 6'b0 ||
            {ctrl_out, rdata, bresp, rresp} !== '0) begin
            bad++; $display("FAIL mid_reset got=%b ctrl=%h rdata=%h exp all zero",
                            {awready, wready, arready, bvalid, rvalid, irq_out}, ctrl_out, rdata);
        end
        axi_aresetn = 1; tick();
        send_both(32'h1C, 32'h1234_5678, 4'hF);
        axi_aresetn = 0; tick(); axi_aresetn = 1; tick();
        total++;
        if ({awready, wready, arready, bvalid} !== 4'b1110) begin
            bad++; $display("FAIL abort_rdy got=%b exp=1110", {awready, wready, arready, bvalid});
        end
        foreach (ra[i]) push_exp(32'h0, 2'b00);
        foreach (ra[i]) begin
            read_reg(ra[i], d, r);
            e = sb.pop_front();
            total++;
            if (d !== e.d || r !== e.r) begin
                bad++; $display("FAIL post_reset_rd[%h] got=%h/%b exp=%h/%b", ra[i], d, r, e.d, e.r);
            end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_aw_then_w();
        test_strobe();
        test_id_oor();
        test_back_to_back();
        test_irq();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
